// File: rtl/led_cmd_receiver_pkg.sv
// ----------------------------------------------------------------------------
// led_cmd_receiver_pkg
// Shared definitions for the LED controller command path: instruction
// encodings, error codes, receiver FSM state encodings and default frame
// geometry. Also consumed by the downstream LED state register.
// ----------------------------------------------------------------------------
package led_cmd_receiver_pkg;

    // Default frame geometry
    localparam int NBITS_DEF   = 8;
    localparam int INSTR_W_DEF = 3;
    localparam int ADDR_W_DEF  = 5;
    localparam int NLEDS_DEF   = 25;

    // Instruction encodings (values above INSTR_PAT are rejected)
    localparam logic [2:0] INSTR_OFF = 3'd0;
    localparam logic [2:0] INSTR_ON  = 3'd1;
    localparam logic [2:0] INSTR_PAT = 3'd2;

    // ERR_CODE encodings
    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_FIELD   = 2'b11;

    // Receiver FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;  // no bits received
    localparam logic [1:0] ST_RECV = 2'd1;  // 1..NBITS-1 bits received
    localparam logic [1:0] ST_FULL = 2'd2;  // exactly NBITS bits received
    localparam logic [1:0] ST_OVER = 2'd3;  // more than NBITS bits received

endpackage

// File: rtl/led_cmd_receiver_sync.sv
// ----------------------------------------------------------------------------
// sync_edge
// Brings one asynchronous pin into the CLK domain through a STAGES-deep
// flop chain and provides a registered rising-edge pulse.
// Ports:
//   CLK    in   system clock
//   RESET  in   synchronous, active-low reset
//   din    in   asynchronous input pin
//   level  out  synchronized level (last chain stage)
//   rise   out  one-CLK pulse, registered, one cycle after level rises
// ----------------------------------------------------------------------------
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync_q  <= '0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage capture the
            // previous stage's old value, so the chain really is STAGES deep.
            sync_q  <= {sync_q[STAGES-2:0], din};
            level_d <= sync_q[STAGES-1];
            rise    <= sync_q[STAGES-1] & ~level_d;
        end
    end

    assign level = sync_q[STAGES-1];

endmodule

// File: rtl/led_cmd_receiver.sv
// ----------------------------------------------------------------------------
// led_cmd_receiver
// Oversamples the MCU serial link (SCLK/SDATA/LATCH) on CLK, deserializes
// MSB-first frames, validates them on the LATCH rising edge and emits
// one-cycle command or error strobes.
// Ports:
//   CLK        in   system clock
//   RESET      in   synchronous, active-low reset
//   SCLK       in   async serial clock; data taken on its rising edge
//   SDATA      in   async serial data, MSB first
//   LATCH      in   async frame-end strobe; rising edge commits the frame
//   CMD_VALID  out  one-CLK pulse, CMD_INSTR/CMD_ADDR carry a new command
//   CMD_INSTR  out  instruction of the last valid command
//   CMD_ADDR   out  LED index of the last valid command
//   CMD_ERR    out  one-CLK pulse, frame rejected
//   ERR_CODE   out  cause of the last rejection
// ----------------------------------------------------------------------------
module led_cmd_receiver
    import led_cmd_receiver_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NLEDS       = NLEDS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SCLK,
    input  logic               SDATA,
    input  logic               LATCH,
    output logic               CMD_VALID,
    output logic [INSTR_W-1:0] CMD_INSTR,
    output logic [ADDR_W-1:0]  CMD_ADDR,
    output logic               CMD_ERR,
    output logic [1:0]         ERR_CODE
);

    localparam int CW = $clog2(NBITS + 2);
    localparam int TW = $clog2(TIMEOUT);

    logic sclk_sync, sclk_rise;
    logic latch_sync, latch_rise;
    logic sdata_sync, sdata_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (SCLK),
        .level (sclk_sync),
        .rise  (sclk_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_latch (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (LATCH),
        .level (latch_sync),
        .rise  (latch_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sdata (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (SDATA),
        .level (sdata_sync),
        .rise  (sdata_rise)
    );

    // Only the SCLK edge and the SDATA level are used.
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_sync, sdata_rise};

    logic [1:0]       state, state_next;
    logic [CW-1:0]    bitcnt;
    logic [NBITS-1:0] shreg;
    logic [TW-1:0]    tcnt;

    // A held LATCH freezes the shifter; a coincident LATCH edge drops the bit.
    logic shift_en;
    assign shift_en = sclk_rise & ~latch_sync & ~latch_rise;

    logic [INSTR_W-1:0] f_instr;
    logic [ADDR_W-1:0]  f_addr;
    logic               frame_ok;
    logic               timeout_hit;

    assign f_instr  = shreg[NBITS-1:ADDR_W];
    assign f_addr   = shreg[ADDR_W-1:0];
    // Address compared one bit wider so NLEDS == 2**ADDR_W still works.
    assign frame_ok = (f_instr <= INSTR_W'(INSTR_PAT)) &&
                      ({1'b0, f_addr} < (ADDR_W + 1)'(NLEDS));

    assign timeout_hit = (state != ST_IDLE) && !shift_en &&
                         (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (shift_en) state_next = ST_RECV;
            ST_RECV: if (shift_en && bitcnt == CW'(NBITS - 1)) state_next = ST_FULL;
            ST_FULL: if (shift_en) state_next = ST_OVER;
            default: state_next = ST_OVER;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            tcnt      <= '0;
            CMD_VALID <= 1'b0;
            CMD_ERR   <= 1'b0;
            CMD_INSTR <= '0;
            CMD_ADDR  <= '0;
            ERR_CODE  <= ERR_TIMEOUT;
        end else begin
            CMD_VALID <= 1'b0;
            CMD_ERR   <= 1'b0;

            if (latch_rise) begin
                // Judge the frame on the bits already counted, then rearm.
                case (state)
                    ST_FULL: begin
                        if (frame_ok) begin
                            CMD_VALID <= 1'b1;
                            CMD_INSTR <= f_instr;
                            CMD_ADDR  <= f_addr;
                        end else begin
                            CMD_ERR  <= 1'b1;
                            ERR_CODE <= ERR_FIELD;
                        end
                    end
                    ST_RECV: begin
                        CMD_ERR  <= 1'b1;
                        ERR_CODE <= ERR_SHORT;
                    end
                    ST_OVER: begin
                        CMD_ERR  <= 1'b1;
                        ERR_CODE <= ERR_OVERRUN;
                    end
                    default: ;  // LATCH with no bits: ignored
                endcase
                state  <= ST_IDLE;
                bitcnt <= '0;
                shreg  <= '0;
                tcnt   <= '0;
            end else if (timeout_hit) begin
                CMD_ERR  <= 1'b1;
                ERR_CODE <= ERR_TIMEOUT;
                state    <= ST_IDLE;
                bitcnt   <= '0;
                shreg    <= '0;
                tcnt     <= '0;
            end else begin
                state <= state_next;
                if (shift_en) begin
                    shreg <= {shreg[NBITS-2:0], sdata_sync};
                    if (bitcnt != CW'(NBITS + 1))
                        bitcnt <= bitcnt + CW'(1);
                end
                if (state == ST_IDLE || shift_en)
                    tcnt <= '0;
                else
                    tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule
